// File: rtl/uart_byte_tx.sv
// UART byte transmitter: start, 8 data LSB-first, optional parity, stop.
// One-cycle done strobe after the stop bit; valid ignored while busy.
module uart_byte_tx #(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int BAUD_RATE   = 115200,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_data_valid,
  input  logic [7:0] tx_data,
  output logic       tx_pin,
  output logic       tx_data_ready,
  output logic       tx_busy
);

  localparam int CPB = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CW  = (CPB > 2) ? $clog2(CPB) : 1;

  generate
    if (CPB < 2) begin : g_bad_cpb
      $error("uart_byte_tx: CLK_FREQ_HZ/BAUD_RATE must be >= 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_par;
  logic          r_pin;
  logic          r_rdy;
  logic          r_busy;

  logic          w_tick;
  logic          w_par;

  // Bit boundary: baud counter at its last count
  assign w_tick = (r_baud == CW'(CPB - 1));
  // Parity of the byte being accepted, inverted for odd parity
  assign w_par  = (^tx_data) ^ (PARITY_ODD != 0);

  // Frame sequencer with registered line, done strobe and busy flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_pin   <= 1'b1;
      r_rdy   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_rdy <= 1'b0;
      if (r_state != S_IDLE) begin
        r_baud <= w_tick ? '0 : r_baud + CW'(1);
      end
      unique case (r_state)
        S_IDLE: begin
          r_baud <= '0;
          r_bit  <= '0;
          if (tx_data_valid) begin
            r_shift <= tx_data;
            r_par   <= w_par;
            r_pin   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_tick) begin
            r_pin   <= r_shift[0];
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_tick) begin
            if (r_bit == 3'd7) begin
              r_bit <= '0;
              if (PARITY_EN != 0) begin
                r_pin   <= r_par;
                r_state <= S_PARITY;
              end else begin
                r_pin   <= 1'b1;
                r_state <= S_STOP;
              end
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_shift <= {1'b0, r_shift[7:1]};
              r_pin   <= r_shift[1];
            end
          end
        end
        S_PARITY: begin
          if (w_tick) begin
            r_pin   <= 1'b1;
            r_state <= S_STOP;
          end
        end
        S_STOP: begin
          if (w_tick) begin
            r_rdy   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_pin   <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign tx_pin        = r_pin;
  assign tx_data_ready = r_rdy;
  assign tx_busy       = r_busy;

endmodule

// File: tb/tb_uart_byte_tx.sv
// Bench for uart_byte_tx: three parity variants against a frame-level
// model, plus directed latency, decode, reset and back-to-back scenarios.
module tb_uart_byte_tx;

  localparam int CLK_HZ = 1000000;
  localparam int BAUD   = 100000;
  localparam int CPB    = CLK_HZ / BAUD;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       vld   = 1'b0;
  logic [7:0] dat   = 8'h00;
  logic [2:0] pin;
  logic [2:0] rdy;
  logic [2:0] busy;

  int checks   = 0;
  int failures = 0;
  int ndone    = 0;
  int nbusy    = 0;
  bit mon_en   = 1'b0;

  always #5 clk = ~clk;

  uart_byte_tx #(
    .CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD),
    .PARITY_EN(0), .PARITY_ODD(0)
  ) u_np (
    .clk(clk), .rst_n(rst_n), .tx_data_valid(vld), .tx_data(dat),
    .tx_pin(pin[0]), .tx_data_ready(rdy[0]), .tx_busy(busy[0])
  );

  uart_byte_tx #(
    .CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD),
    .PARITY_EN(1), .PARITY_ODD(0)
  ) u_pe (
    .clk(clk), .rst_n(rst_n), .tx_data_valid(vld), .tx_data(dat),
    .tx_pin(pin[1]), .tx_data_ready(rdy[1]), .tx_busy(busy[1])
  );

  uart_byte_tx #(
    .CLK_FREQ_HZ(CLK_HZ), .BAUD_RATE(BAUD),
    .PARITY_EN(1), .PARITY_ODD(1)
  ) u_po (
    .clk(clk), .rst_n(rst_n), .tx_data_valid(vld), .tx_data(dat),
    .tx_pin(pin[2]), .tx_data_ready(rdy[2]), .tx_busy(busy[2])
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Frame model: expected line value indexed by cycles since acceptance
  int         age[3] = '{-1, -1, -1};
  logic [10:0] fr[3];
  int         nb[3];
  logic       mrdy[3] = '{1'b0, 1'b0, 1'b0};

  function automatic bit pen(input int d);
    return d != 0;
  endfunction

  function automatic bit podd(input int d);
    return d == 2;
  endfunction

  function automatic logic [10:0] mk(input int d, input logic [7:0] b);
    logic [10:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = b;
    if (pen(d)) f[9] = (^b) ^ podd(d);
    return f;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < 3; d++) begin
      if (!rst_n) begin
        age[d]  = -1;
        mrdy[d] = 1'b0;
      end else begin
        mrdy[d] = 1'b0;
        if (age[d] < 0) begin
          if (vld) begin
            age[d] = 0;
            fr[d]  = mk(d, dat);
            nb[d]  = pen(d) ? 11 : 10;
          end
        end else begin
          age[d]++;
          if (age[d] == nb[d] * CPB) begin
            age[d]  = -1;
            mrdy[d] = 1'b1;
          end
        end
      end
    end
  end

  // Per-cycle comparison of every instance against the model
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("pin%0d", d), pin[d],
            (age[d] < 0) ? 1'b1 : fr[d][age[d] / CPB]);
        chk($sformatf("busy%0d", d), busy[d], age[d] >= 0);
        chk($sformatf("rdy%0d", d), rdy[d], mrdy[d]);
      end
      if (rdy[0]) ndone++;
      if (busy[0]) nbusy++;
    end
  end

  // Call at a negedge; drives a one-cycle valid strobe
  task automatic issue(input logic [7:0] b);
    vld = 1'b1;
    dat = b;
    @(negedge clk);
    vld = 1'b0;
    dat = 8'($urandom);
  endtask

  // Follows one no-parity frame, decoding data mid-bit; spur>0 injects
  // a stray valid at that cycle
  task automatic track(input logic [7:0] b, input string tag,
                       input int spur);
    int k;
    logic [7:0] rx;
    rx = '0;
    k  = 0;
    while (k < 200) begin
      @(negedge clk);
      k++;
      if (k == spur) begin
        vld = 1'b1;
        dat = 8'($urandom);
      end else begin
        vld = 1'b0;
      end
      if (k >= 15 && k <= 85 && (k % 10) == 5) rx[(k - 15) / 10] = pin[0];
      if (rdy[0]) break;
    end
    chk({tag, "_lat"}, k, 100);
    chk({tag, "_byte"}, rx, b);
  endtask

  task automatic settle();
    repeat (130) @(negedge clk);
  endtask

  initial begin
    int k;
    int d0;
    logic [31:0] word;
    logic [7:0] b;

    repeat (3) @(negedge clk);
    chk("rst_pin", pin, 3'b111);
    chk("rst_busy", busy, 3'b000);
    chk("rst_rdy", rdy, 3'b000);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    repeat (3) @(negedge clk);

    nbusy = 0;
    d0    = ndone;
    issue(8'hA5);
    track(8'hA5, "a5", 0);
    settle();
    chk("a5_busy", nbusy, 100);
    chk("a5_done", ndone - d0, 1);

    issue(8'h07);
    k = 0;
    while (k < 200 && !rdy[1]) begin
      @(negedge clk);
      k++;
      if (k == 95) begin
        chk("par_even", pin[1], 1'b1);
        chk("par_odd", pin[2], 1'b0);
      end
    end
    chk("par_lat", k, 110);
    settle();

    d0 = ndone;
    issue(8'h55);
    track(8'h55, "ign", 30);
    settle();
    chk("ign_done", ndone - d0, 1);

    issue(8'h34);
    track(8'h34, "b2b_a", 0);
    issue(8'h12);
    track(8'h12, "b2b_b", 0);
    settle();

    d0 = ndone;
    issue(8'($urandom));
    repeat (44) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pin", pin, 3'b111);
    chk("mid_rst_busy", busy, 3'b000);
    chk("mid_rst_rdy", rdy, 3'b000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    settle();
    chk("mid_rst_nodone", ndone - d0, 0);
    issue(8'h3C);
    track(8'h3C, "post_rst", 0);
    settle();

    d0   = ndone;
    word = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) begin
      b = word[31 - 8 * i -: 8];
      issue(b);
      track(b, $sformatf("seq%0d", i), 0);
    end
    settle();
    chk("seq_done", ndone - d0, 4);

    for (int i = 0; i < 20; i++) begin
      b = 8'($urandom);
      issue(b);
      track(b, $sformatf("rnd%0d", i),
            int'($urandom_range(0, 3)) == 0 ? 0 : int'($urandom_range(1, 95)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_byte_tx.md
Name: uart_byte_tx

Overview:
- Serial UART byte transmitter. It sits directly downstream of the 4-byte command sequencer and drives the lidar module's TXD line.
- Accepts one byte on a one-cycle valid strobe and shifts it out LSB-first as start / 8 data / optional parity / stop.
- Signals completion with a one-cycle done strobe. The sequencer polls this strobe before issuing the next byte.

Parameters:
- CLK_FREQ_HZ, 50000000, system clock frequency in Hz.
- BAUD_RATE, 115200, line bit rate.
- PARITY_EN, 0, 1 inserts a parity bit between D7 and stop.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- tx_data_valid  input  1  one-cycle request strobe; byte accepted only in IDLE.
- tx_data  input  8  byte to send; sampled on the accepting edge.
- tx_pin  output  1  serial line, idle high; registered.
- tx_data_ready  output  1  one-cycle done pulse after the stop bit completes; registered.
- tx_busy  output  1  high from the accepting edge until the edge that pulses tx_data_ready.

Behaviour:
- Derived constant: CPB = CLK_FREQ_HZ / BAUD_RATE (integer division). CPB >= 2 is required; elaboration fails otherwise.
- Reset values: tx_pin=1, tx_data_ready=0, tx_busy=0, state=IDLE, bit counter=0, baud counter=0, shift register=0. Reset mid-frame aborts the frame immediately; no done pulse is issued.
- States:
  - IDLE -> START on tx_data_valid=1. tx_data is latched into the shift register, tx_pin<=0, tx_busy<=1.
  - START: hold 0 for CPB cycles -> DATA. tx_pin<=shift[0].
  - DATA: each CPB cycles, shift right and present the next bit. After bit 7 completes -> PARITY if PARITY_EN, else -> STOP. tx_pin<=1 on entering STOP.
  - PARITY: tx_pin = XOR of the latched byte, XOR PARITY_ODD; held CPB cycles -> STOP.
  - STOP: hold 1 for CPB cycles. Then -> IDLE, tx_data_ready<=1 for exactly one cycle, tx_busy<=0.
- Counters:
  - Baud counter counts 0..CPB-1 and reloads to 0 on each bit boundary.
  - Bit counter is 3 bits, 0..7 within DATA.
- Timing: the accepting edge is E. The start bit is visible on tx_pin from E for CPB cycles. The done pulse is driven at edge E + 10*CPB (E + 11*CPB with parity).
- tx_data_valid while busy: ignored. No queuing, no effect on the frame in flight, no error flag.
- tx_data changes after acceptance have no effect.
- Valid in the same cycle tx_data_ready is high: the state is already IDLE, so the new byte is accepted. This gives back-to-back frames with no idle gap beyond that one cycle.
- tx_data_ready is never high in two consecutive cycles and never high without a preceding accepted byte.
- tx_pin is glitch-free: registered, and changes only on bit boundaries.

Test Plan:
1. Sim params CLK_FREQ_HZ=1000000, BAUD_RATE=100000 (CPB=10). Reset, then pulse valid with tx_data=0xA5. Required response:
   - tx_pin shows 0 for 10 cycles, then 1,0,1,0,0,1,0,1 at 10 cycles each, then 1 for 10 cycles.
   - tx_data_ready pulses once, 100 cycles after the accepting edge.
   - tx_busy is high for exactly 100 cycles.
2. PARITY_EN=1, PARITY_ODD=0, byte 0x07. The parity bit is 1 and the frame is 110 cycles. Repeat with PARITY_ODD=1: the parity bit is 0.
3. Pulse valid with 0x55, then pulse valid with 0xFF at cycle 30. The 0xFF request is ignored: the waveform is exactly the 0x55 frame and only one done pulse occurs.
4. Issue valid 0x12 in the same cycle as the done pulse of 0x34. 0x12 is accepted: its start bit begins on that edge and a second done pulse follows 100 cycles later.
5. Assert rst_n=0 at cycle 45 of a frame. tx_pin=1, tx_busy=0 and tx_data_ready=0 immediately. No done pulse is issued. A fresh byte sent after release transmits correctly.
6. Drive the four-byte sequencer with 0xDEADBEEF. Bytes DE, AD, BE, EF appear in order and four done pulses occur. The sequencer's txd_done asserts after the fourth done pulse.
